// File: rtl/mem_probe_pkg.sv
// Shared types and helpers for the SDRAM size probe.
// Contents:
//   state_t      - sequencer states
//   iss_state_t  - request issuer states
//   probe_addr() - word address of probe k
//   sig()        - signature written to probe k (caller truncates to the data width)
//   clear_limit()- number of words to clear for a given present[] vector
// All helpers return 32-bit values, so the address width must be at most 31.
package mem_probe_pkg;

  typedef enum logic [3:0] {
    StWaitRdy,
    StWr,
    StWrDummy,
    StRd,
    StEval,
    StClear,
    StVerify,
    StDone,
    StFail
  } state_t;

  typedef enum logic [1:0] {
    IsIdle,
    IsGap,
    IsWait
  } iss_state_t;

  // Probe 0 sits at address 0; the others sit on the top PROBES-1 address bits.
  function automatic logic [31:0] probe_addr(input int unsigned k, input int unsigned addr_w,
                                             input int unsigned probes);
    if (k == 0) return '0;
    return 32'(1) << (addr_w - probes + k);
  endfunction

  function automatic logic [31:0] sig(input int unsigned k, input int unsigned sig_base);
    return sig_base * (k + 1);
  endfunction

  // Size is set by the highest probe bit that read back its own signature.
  function automatic logic [31:0] clear_limit(input logic [31:0] present,
                                              input int unsigned addr_w,
                                              input int unsigned probes);
    int unsigned h;
    h = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < probes && present[i[4:0]]) h = i;
    end
    return 32'(1) << (addr_w - probes + h + 1);
  endfunction

endpackage

// File: rtl/mem_req_issuer.sv
// Single-word request issuer for a ready/rd/we memory controller.
// A request from the sequencer is accepted only while idle with mem_ready=1. The rd/we pulse
// lasts one cycle; that cycle is the GAP, during which mem_ready is ignored because the
// controller has not yet dropped it. The issuer then waits for mem_ready=1 and strobes ack,
// which is also the cycle in which read data on mem_dout is valid.
// Ports:
//   clk_sys, reset      clock, async active-high reset (abandons any in-flight op)
//   req_rd, req_we      sequencer wants a read / write (level, held until ack)
//   req_addr, req_data  address / write data for the request
//   mem_ready           controller idle / data valid
//   accept              request taken this cycle
//   ack                 request completed this cycle
//   mem_addr, mem_din   registered request address / write data
//   mem_rd, mem_we      registered one-cycle request pulses
module mem_req_issuer
  import mem_probe_pkg::*;
#(
  parameter int unsigned ADDR_W = 27,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              req_rd,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic              mem_ready,
  output logic              accept,
  output logic              ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_rd,
  output logic              mem_we
);

  iss_state_t st_q;

  assign accept = (st_q == IsIdle) && mem_ready && (req_rd || req_we);
  assign ack    = (st_q == IsWait) && mem_ready;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      st_q     <= IsIdle;
      mem_rd   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
    end else begin
      mem_rd <= 1'b0;
      mem_we <= 1'b0;
      unique case (st_q)
        IsIdle: begin
          if (accept) begin
            mem_rd   <= req_rd;
            mem_we   <= req_we & ~req_rd;
            mem_addr <= req_addr;
            if (req_we) mem_din <= req_data;
            st_q     <= IsGap;
          end
        end
        IsGap:   st_q <= IsWait;
        IsWait:  if (mem_ready) st_q <= IsIdle;
        default: st_q <= IsIdle;
      endcase
    end
  end

endmodule

// File: rtl/mem_size_probe.sv
// SDRAM size probe and clear sequencer.
// Writes a signature to each probe address (highest first), writes a dummy pattern to discharge
// the bus, reads the probes back to find which address bits are decoded, then zero-fills
// 0..L-1 of the detected size. present[] reports which probes held their signature.
// Build option: define MEM_PROBE_VERIFY_EN to add a read-back sweep of 0..L-1 after the clear;
// any non-zero word sets the sticky verr flag (the run still ends in done). Without it verr=0.
// Ports:
//   clk_sys, reset      clock, async active-high reset
//   restart             one-cycle pulse, reruns the sequence from done/fail
//   mem_ready, mem_dout controller ready level and read data
//   mem_addr, mem_din   request address / write data
//   mem_rd, mem_we      one-cycle request pulses
//   present             per-probe signature match
//   busy, done, fail    sequence status (done/fail held until restart/reset)
//   verr                verify mismatch seen
module mem_size_probe
  import mem_probe_pkg::*;
#(
  parameter int unsigned ADDR_W    = 27,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned PROBES    = 3,
  parameter int unsigned SIG_BASE  = 1032,
  parameter int unsigned DUMMY     = 12345,
  parameter int unsigned CLEAR_GAP = 32
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              restart,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_rd,
  output logic              mem_we,
  output logic [PROBES-1:0] present,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic              verr
);

  localparam int unsigned KW   = (PROBES > 1) ? $clog2(PROBES) : 1;
  localparam int unsigned GW   = $clog2(CLEAR_GAP + 1);
  localparam int unsigned CntW = ADDR_W + 1;

  localparam logic [KW-1:0]     KMax      = KW'(PROBES - 1);
  localparam logic [ADDR_W-1:0] DummyAddr = ADDR_W'(32'(1) << (ADDR_W - PROBES));
  localparam logic [DATA_W-1:0] DummyPat  = DATA_W'(DUMMY);
  localparam logic [GW-1:0]     GapMin    = GW'(CLEAR_GAP);
  localparam logic [GW-1:0]     GapOne    = GW'(1);
  localparam logic [CntW-1:0]   CntOne    = CntW'(1);

  state_t            state_q;
  logic [KW-1:0]     k_q;
  // One bit wider than the address so a full-size limit (1<<ADDR_W) is representable.
  logic [CntW-1:0]   cnt_q;
  logic [CntW-1:0]   limit_q;
  logic [GW-1:0]     gap_q;
`ifdef MEM_PROBE_VERIFY_EN
  logic              verr_q;
`endif

  logic              req_rd;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              accept;
  logic              ack;
  logic [ADDR_W-1:0] probe_a;
  logic [DATA_W-1:0] sig_k;
  logic              last_addr;

  assign probe_a   = ADDR_W'(probe_addr(32'(k_q), ADDR_W, PROBES));
  assign sig_k     = DATA_W'(sig(32'(k_q), SIG_BASE));
  assign last_addr = (cnt_q == limit_q - CntOne);

  always_comb begin
    req_rd   = 1'b0;
    req_we   = 1'b0;
    req_addr = '0;
    req_data = '0;
    case (state_q)
      StWr: begin
        req_we   = 1'b1;
        req_addr = probe_a;
        req_data = sig_k;
      end
      StWrDummy: begin
        req_we   = 1'b1;
        req_addr = DummyAddr;
        req_data = DummyPat;
      end
      StRd: begin
        req_rd   = 1'b1;
        req_addr = probe_a;
      end
      StClear: begin
        // Hold off until the minimum spacing since the previous issue has elapsed.
        req_we   = (gap_q >= GapMin);
        req_addr = cnt_q[ADDR_W-1:0];
      end
`ifdef MEM_PROBE_VERIFY_EN
      StVerify: begin
        req_rd   = 1'b1;
        req_addr = cnt_q[ADDR_W-1:0];
      end
`endif
      default: ;
    endcase
  end

  mem_req_issuer #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_issuer (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .req_rd   (req_rd),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_data (req_data),
    .mem_ready(mem_ready),
    .accept   (accept),
    .ack      (ack),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_rd   (mem_rd),
    .mem_we   (mem_we)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= StWaitRdy;
      k_q     <= '0;
      cnt_q   <= '0;
      limit_q <= '0;
      gap_q   <= GapMin;
      present <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      fail    <= 1'b0;
`ifdef MEM_PROBE_VERIFY_EN
      verr_q  <= 1'b0;
`endif
    end else begin
      if (accept) gap_q <= GapOne;
      else if (gap_q < GapMin) gap_q <= gap_q + GapOne;

      case (state_q)
        StWaitRdy: begin
          if (mem_ready) begin
            state_q <= StWr;
            k_q     <= KMax;
            busy    <= 1'b1;
          end
        end
        StWr: begin
          if (ack) begin
            if (k_q == '0) state_q <= StWrDummy;
            else k_q <= k_q - 1'b1;
          end
        end
        StWrDummy: begin
          if (ack) begin
            state_q <= StRd;
            k_q     <= KMax;
          end
        end
        StRd: begin
          if (ack) begin
            present[k_q] <= (mem_dout == sig_k);
            if (k_q == '0) state_q <= StEval;
            else k_q <= k_q - 1'b1;
          end
        end
        StEval: begin
          cnt_q   <= '0;
          limit_q <= CntW'(clear_limit(32'(present), ADDR_W, PROBES));
          if (present == '0) begin
            state_q <= StFail;
            fail    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            state_q <= StClear;
          end
        end
        StClear: begin
          if (ack) begin
            if (last_addr) begin
`ifdef MEM_PROBE_VERIFY_EN
              state_q <= StVerify;
              cnt_q   <= '0;
`else
              state_q <= StDone;
              done    <= 1'b1;
              busy    <= 1'b0;
`endif
            end else begin
              cnt_q <= cnt_q + CntOne;
            end
          end
        end
`ifdef MEM_PROBE_VERIFY_EN
        StVerify: begin
          if (ack) begin
            if (mem_dout != '0) verr_q <= 1'b1;
            if (last_addr) begin
              state_q <= StDone;
              done    <= 1'b1;
              busy    <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CntOne;
            end
          end
        end
`endif
        StDone, StFail: begin
          if (restart) begin
            state_q <= StWaitRdy;
            present <= '0;
            done    <= 1'b0;
            fail    <= 1'b0;
`ifdef MEM_PROBE_VERIFY_EN
            verr_q  <= 1'b0;
`endif
          end
        end
        default: state_q <= StWaitRdy;
      endcase
    end
  end

`ifdef MEM_PROBE_VERIFY_EN
  assign verr = verr_q;
`else
  assign verr = 1'b0;
`endif

endmodule

// File: tb/tb_mem_size_probe.sv
module tb_mem_size_probe;

  localparam int unsigned ADDR_W    = 12;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned PROBES    = 3;
  localparam int unsigned CLEAR_GAP = 4;
`ifdef MEM_PROBE_VERIFY_EN
  localparam logic VerifyBuild = 1'b1;
`else
  localparam logic VerifyBuild = 1'b0;
`endif

  logic              clk_sys = 1'b0;
  logic              reset   = 1'b1;
  logic              restart = 1'b0;
  logic              mem_ready = 1'b1;
  logic [DATA_W-1:0] mem_dout = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              mem_rd;
  logic              mem_we;
  logic [PROBES-1:0] present;
  logic              busy;
  logic              done;
  logic              fail;
  logic              verr;

  always #5 clk_sys = ~clk_sys;

  mem_size_probe #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .PROBES   (PROBES),
    .SIG_BASE (1032),
    .DUMMY    (12345),
    .CLEAR_GAP(CLEAR_GAP)
  ) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .restart  (restart),
    .mem_ready(mem_ready),
    .mem_dout (mem_dout),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_rd   (mem_rd),
    .mem_we   (mem_we),
    .present  (present),
    .busy     (busy),
    .done     (done),
    .fail     (fail),
    .verr     (verr)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Controller model: one busy cycle per request, address aliasing via mask, optional
  // long stall on a chosen write and an optional bad word at 0x055.
  logic [DATA_W-1:0] mem [0:4095];
  logic [ADDR_W-1:0] mask = 12'hFFF;
  int  busy_cnt = 0;
  int  wr_cnt   = 0;
  int  stall_at = -1;
  bit  fault_en = 1'b0;

  always @(posedge clk_sys) begin
    if (mem_we) begin
      mem[mem_addr & mask] <= mem_din;
      wr_cnt <= wr_cnt + 1;
    end
    if (mem_rd) mem_dout <= (fault_en && mem_addr == 12'h055) ? 16'h0001 : mem[mem_addr & mask];
    if (mem_we || mem_rd) begin
      mem_ready <= 1'b0;
      busy_cnt  <= (mem_we && wr_cnt == stall_at) ? 99 : 0;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      mem_ready <= 1'b1;
    end
  end

  // Scoreboard of expected requests.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              is_clear;
  } req_t;
  req_t sb_q[$];
  int   since_we = 100;

  always @(negedge clk_sys) begin
    if (mem_rd || mem_we) begin
      check("req_rdy", {31'd0, mem_ready}, 32'd1);
      if (sb_q.size() == 0) begin
        check("sb_unexpected", sb_q.size(), 32'd1);
      end else begin
        check("req", {mem_rd, mem_we, mem_addr, mem_we ? mem_din : 16'h0},
              {~sb_q[0].we, sb_q[0].we, sb_q[0].addr, sb_q[0].we ? sb_q[0].data : 16'h0});
        if (sb_q[0].is_clear) check("clr_gap", {31'd0, since_we >= CLEAR_GAP}, 32'd1);
        sb_q.delete(0);
      end
    end
    since_we <= mem_we ? 1 : since_we + 1;
  end

  task automatic push_run(input logic [2:0] pres);
    int unsigned lim;
    sb_q.push_back('{we: 1'b1, addr: 12'h800, data: 16'd3096, is_clear: 1'b0});
    sb_q.push_back('{we: 1'b1, addr: 12'h400, data: 16'd2064, is_clear: 1'b0});
    sb_q.push_back('{we: 1'b1, addr: 12'h000, data: 16'd1032, is_clear: 1'b0});
    sb_q.push_back('{we: 1'b1, addr: 12'h200, data: 16'd12345, is_clear: 1'b0});
    sb_q.push_back('{we: 1'b0, addr: 12'h800, data: 16'h0, is_clear: 1'b0});
    sb_q.push_back('{we: 1'b0, addr: 12'h400, data: 16'h0, is_clear: 1'b0});
    sb_q.push_back('{we: 1'b0, addr: 12'h000, data: 16'h0, is_clear: 1'b0});
    lim = pres[2] ? 4096 : pres[1] ? 2048 : pres[0] ? 1024 : 0;
    for (int unsigned a = 0; a < lim; a++)
      sb_q.push_back('{we: 1'b1, addr: a[11:0], data: 16'h0, is_clear: 1'b1});
`ifdef MEM_PROBE_VERIFY_EN
    for (int unsigned a = 0; a < lim; a++)
      sb_q.push_back('{we: 1'b0, addr: a[11:0], data: 16'h0, is_clear: 1'b0});
`endif
  endtask

  task automatic pulse_restart(input string tag);
    @(negedge clk_sys) restart = 1'b1;
    @(negedge clk_sys) restart = 1'b0;
    check({tag, "_rs_present"}, {29'd0, present}, 32'd0);
    check({tag, "_rs_done"}, {31'd0, done}, 32'd0);
    check({tag, "_rs_fail"}, {31'd0, fail}, 32'd0);
    check({tag, "_rs_verr"}, {31'd0, verr}, 32'd0);
  endtask

  task automatic end_run(input string tag, input logic [2:0] p, input logic f, input logic v);
    int n;
    n = 0;
    while (!(done || fail) && n < 40000) begin
      @(negedge clk_sys);
      n++;
    end
    check({tag, "_timeout"}, {31'd0, done || fail}, 32'd1);
    repeat (10) @(negedge clk_sys);
    check({tag, "_present"}, {29'd0, present}, {29'd0, p});
    check({tag, "_done"}, {31'd0, done}, {31'd0, ~f});
    check({tag, "_fail"}, {31'd0, fail}, {31'd0, f});
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_verr"}, {31'd0, verr}, {31'd0, v});
    check({tag, "_sb_left"}, sb_q.size(), 32'd0);
  endtask

  initial begin
    int n;
    // 1: reset state, then full-size model (bad word at 0x055 in the verify build)
    fault_en = VerifyBuild;
    repeat (3) @(negedge clk_sys);
    check("rst_present", {29'd0, present}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_fail", {31'd0, fail}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_verr", {31'd0, verr}, 32'd0);
    check("rst_rd", {31'd0, mem_rd}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_addr", {20'd0, mem_addr}, 32'd0);
    check("rst_din", {16'd0, mem_din}, 32'd0);
    push_run(3'b111);
    reset = 1'b0;
    repeat (50) @(negedge clk_sys);
    check("t1_busy_mid", {31'd0, busy}, 32'd1);
    restart = 1'b1;  // ignored while busy
    @(negedge clk_sys) restart = 1'b0;
    end_run("t1", 3'b111, 1'b0, VerifyBuild);

    // 2+5: 2048-word model with a 100-cycle ready stall after the second write
    fault_en = 1'b0;
    mask     = 12'h7FF;
    stall_at = wr_cnt + 1;
    push_run(3'b011);
    pulse_restart("t2");
    end_run("t2", 3'b011, 1'b0, 1'b0);
    stall_at = -1;

    // 3: 256-word model, every probe aliases onto the dummy word
    mask = 12'h0FF;
    push_run(3'b000);
    pulse_restart("t3");
    end_run("t3", 3'b000, 1'b1, 1'b0);

    // 4: reset in the middle of the clear sweep
    mask = 12'h7FF;
    push_run(3'b011);
    pulse_restart("t4");
    n = 0;
    while (!(mem_we && mem_addr == 12'h123) && n < 5000) begin
      @(negedge clk_sys);
      n++;
    end
    check("t4_hit_123", {31'd0, mem_we && mem_addr == 12'h123}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t4_rst_we", {31'd0, mem_we}, 32'd0);
    check("t4_rst_addr", {20'd0, mem_addr}, 32'd0);
    check("t4_rst_busy", {31'd0, busy}, 32'd0);
    check("t4_rst_present", {29'd0, present}, 32'd0);
    check("t4_rst_done", {31'd0, done || fail || verr}, 32'd0);
    sb_q.delete();
    push_run(3'b011);
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    end_run("t4", 3'b011, 1'b0, 1'b0);

    // 6: 1024-word model, clean rerun after a restart
    mask = 12'h3FF;
    push_run(3'b001);
    pulse_restart("t6");
    end_run("t6", 3'b001, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
